// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Lets two requesters share one single-cycle ALU. A round-robin arbiter picks
// the winner in IDLE. That operation's operands and control code are latched
// into the alu_* registers, so the ALU sees stable inputs for a full cycle.
// The ALU result is captured into rsp_result/rsp_zero. The result is then
// offered on the winner's response port until that requester takes it. Only
// one operation is in flight at a time.
//
// Optional feature (macro ALU_ARB_ILLEGAL_OP_EN):
//   Adds output rsp_err. Control codes other than 010, 110, 000, 001 and 111
//   still run through the FSM. The ALU is driven with add (010), and the
//   response reports result=0, zero=1, err=1.
//   Without the macro, ctrl is forwarded unchanged.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   reqN_valid/ready          request handshake for requester N (0,1)
//   reqN_srca/srcb/ctrl       operands and ALU control code of requester N
//   rspN_valid/ready          response handshake for requester N
//   rsp_result, rsp_zero      registered ALU result/zero, shared by both ports
//   rsp_err                   illegal-op flag (only with ALU_ARB_ILLEGAL_OP_EN)
//   alu_srca/srcb/ctrl        registered operands/control to the ALU
//   alu_out, alu_zero         combinational ALU result
//   busy                      FSM is not idle
//   owner                     index of the current/last granted requester
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_srca,
    input  logic [DATA_W-1:0] req0_srcb,
    input  logic [2:0]        req0_ctrl,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_srca,
    input  logic [DATA_W-1:0] req1_srcb,
    input  logic [2:0]        req1_ctrl,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
`ifdef ALU_ARB_ILLEGAL_OP_EN
    output logic              rsp_err,
`endif

    output logic [DATA_W-1:0] alu_srca,
    output logic [DATA_W-1:0] alu_srcb,
    output logic [2:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,

    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] CTRL_ADD = 3'b010;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] alu_srca_q, alu_srca_d;
    logic [DATA_W-1:0] alu_srcb_q, alu_srcb_d;
    logic [2:0]        alu_ctrl_q, alu_ctrl_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;

    logic              any_valid;
    logic              winner;
    logic [DATA_W-1:0] sel_srca;
    logic [DATA_W-1:0] sel_srcb;
    logic [2:0]        sel_ctrl;
    logic              rsp_take;

`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic              illegal_q, illegal_d;
    logic              rsp_err_q, rsp_err_d;
    logic              sel_illegal;
`endif

    // Arbitration: a lone requester wins outright; on a tie the requester
    // that was not granted last time wins, which makes grants alternate.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        winner    = (req0_valid && req1_valid) ? ~owner_q : req1_valid;
        sel_srca  = winner ? req1_srca : req0_srca;
        sel_srcb  = winner ? req1_srcb : req0_srcb;
        sel_ctrl  = winner ? req1_ctrl : req0_ctrl;
        rsp_take  = owner_q ? rsp1_ready : rsp0_ready;
`ifdef ALU_ARB_ILLEGAL_OP_EN
        case (sel_ctrl)
            3'b010, 3'b110, 3'b000, 3'b001, 3'b111: sel_illegal = 1'b0;
            default:                                sel_illegal = 1'b1;
        endcase
`endif
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        alu_srca_d   = alu_srca_q;
        alu_srcb_d   = alu_srcb_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
        illegal_d    = illegal_q;
        rsp_err_d    = rsp_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d    = EXEC;
                    owner_d    = winner;
                    alu_srca_d = sel_srca;
                    alu_srcb_d = sel_srcb;
`ifdef ALU_ARB_ILLEGAL_OP_EN
                    // An illegal code runs the ALU as a harmless add.
                    // The result is then replaced when it is captured.
                    alu_ctrl_d = sel_illegal ? CTRL_ADD : sel_ctrl;
                    illegal_d  = sel_illegal;
`else
                    alu_ctrl_d = sel_ctrl;
`endif
                end
            end
            EXEC: begin
                state_d = RESP;
`ifdef ALU_ARB_ILLEGAL_OP_EN
                rsp_result_d = illegal_q ? '0 : alu_out;
                rsp_zero_d   = illegal_q ? 1'b1 : alu_zero;
                rsp_err_d    = illegal_q;
`else
                rsp_result_d = alu_out;
                rsp_zero_d   = alu_zero;
`endif
            end
            RESP: begin
                if (rsp_take) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b1;
            alu_srca_q   <= '0;
            alu_srcb_q   <= '0;
            alu_ctrl_q   <= CTRL_ADD;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            illegal_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            alu_srca_q   <= alu_srca_d;
            alu_srcb_q   <= alu_srcb_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            illegal_q    <= illegal_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    // Ready is gated by reset_n. Otherwise a requester holding valid would
    // see ready while the block is held in reset.
    always_comb begin
        req0_ready = reset_n && (state_q == IDLE) && any_valid && !winner;
        req1_ready = reset_n && (state_q == IDLE) && any_valid && winner;
        rsp0_valid = (state_q == RESP) && !owner_q;
        rsp1_valid = (state_q == RESP) && owner_q;
        busy       = (state_q != IDLE);
    end

    assign owner      = owner_q;
    assign alu_srca   = alu_srca_q;
    assign alu_srcb   = alu_srcb_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    assign rsp_err    = rsp_err_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Self-checking bench for alu_share_arbiter. A small behavioural ALU closes
// the loop between alu_* and alu_out/alu_zero. A table of single-request
// transactions is followed by hand-written sequences for round-robin,
// backpressure, mid-operation reset and operand stability. With
// ALU_ARB_ILLEGAL_OP_EN it also covers the illegal-op path.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int DATA_W = 32;

    logic              clk;
    logic              reset_n;
    logic              req0_valid, req0_ready;
    logic [DATA_W-1:0] req0_srca, req0_srcb;
    logic [2:0]        req0_ctrl;
    logic              req1_valid, req1_ready;
    logic [DATA_W-1:0] req1_srca, req1_srcb;
    logic [2:0]        req1_ctrl;
    logic              rsp0_valid, rsp0_ready;
    logic              rsp1_valid, rsp1_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic              rsp_err;
`endif
    logic [DATA_W-1:0] alu_srca, alu_srcb;
    logic [2:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;
    logic              busy;
    logic              owner;

    int checks = 0;
    int errors = 0;

    alu_share_arbiter #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_srca  (req0_srca),
        .req0_srcb  (req0_srcb),
        .req0_ctrl  (req0_ctrl),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_srca  (req1_srca),
        .req1_srcb  (req1_srcb),
        .req1_ctrl  (req1_ctrl),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
`ifdef ALU_ARB_ILLEGAL_OP_EN
        .rsp_err    (rsp_err),
`endif
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_ctrl   (alu_ctrl),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .busy       (busy),
        .owner      (owner)
    );

    // Behavioural single-cycle ALU; unknown codes default to add.
    always_comb begin
        case (alu_ctrl)
            3'b010:  alu_out = alu_srca + alu_srcb;
            3'b110:  alu_out = alu_srca - alu_srcb;
            3'b000:  alu_out = alu_srca & alu_srcb;
            3'b001:  alu_out = alu_srca | alu_srcb;
            3'b111:  alu_out = ($signed(alu_srca) < $signed(alu_srcb)) ? 32'd1 : 32'd0;
            default: alu_out = alu_srca + alu_srcb;
        endcase
        alu_zero = (alu_out == '0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        port;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic port, input logic valid,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] ctrl);
        if (port) begin
            req1_valid = valid; req1_srca = a; req1_srcb = b; req1_ctrl = ctrl;
        end else begin
            req0_valid = valid; req0_srca = a; req0_srcb = b; req0_ctrl = ctrl;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One isolated request on a single port, taken immediately at RESP.
    task automatic runTransaction(input string tag, input logic port,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] ctrl, input logic [2:0] exp_ctrl,
                                  input logic [31:0] exp_res, input logic exp_zero,
                                  input logic exp_err);
        @(negedge clk);
        applyStimulus(port, 1'b1, a, b, ctrl);
        #1;
        checkOutput({tag, " req_ready winner"}, port ? req1_ready : req0_ready, 1);
        checkOutput({tag, " req_ready loser"}, port ? req0_ready : req1_ready, 0);
        @(negedge clk);
        applyStimulus(port, 1'b0, a, b, ctrl);
        #1;
        checkOutput({tag, " busy in EXEC"}, busy, 1);
        checkOutput({tag, " owner"}, owner, port);
        checkOutput({tag, " alu_srca"}, alu_srca, a);
        checkOutput({tag, " alu_srcb"}, alu_srcb, b);
        checkOutput({tag, " alu_ctrl"}, alu_ctrl, exp_ctrl);
        checkOutput({tag, " rsp valid early"}, rsp0_valid | rsp1_valid, 0);
        @(negedge clk);
        #1;
        checkOutput({tag, " rsp_valid owner"}, port ? rsp1_valid : rsp0_valid, 1);
        checkOutput({tag, " rsp_valid other"}, port ? rsp0_valid : rsp1_valid, 0);
        checkOutput({tag, " rsp_result"}, rsp_result, exp_res);
        checkOutput({tag, " rsp_zero"}, rsp_zero, exp_zero);
`ifdef ALU_ARB_ILLEGAL_OP_EN
        checkOutput({tag, " rsp_err"}, rsp_err, exp_err);
`else
        checkOutput({tag, " exp_err unused"}, 0, exp_err);
`endif
        if (port) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #1;
        checkOutput({tag, " rsp_valid after take"}, rsp0_valid | rsp1_valid, 0);
        checkOutput({tag, " busy after take"}, busy, 0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'd5,        32'd3,        3'b010, 32'd8,        1'b0};
        vecs[1] = '{1'b1, 32'd10,       32'd4,        3'b110, 32'd6,        1'b0};
        vecs[2] = '{1'b0, 32'hFFFF0000, 32'h0F0F0F0F, 3'b000, 32'h0F0F0000, 1'b0};
        vecs[3] = '{1'b1, 32'hA,        32'h5,        3'b001, 32'hF,        1'b0};
        vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'd1,        3'b111, 32'd1,        1'b0};
        vecs[5] = '{1'b1, 32'd5,        32'd5,        3'b110, 32'd0,        1'b1};
        vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'd1,        3'b010, 32'd0,        1'b1};
        vecs[7] = '{1'b1, 32'd9,        32'd2,        3'b111, 32'd0,        1'b1};

        reset_n    = 1'b0;
        req0_valid = 1'b0; req0_srca = '0; req0_srcb = '0; req0_ctrl = '0;
        req1_valid = 1'b0; req1_srca = '0; req1_srcb = '0; req1_ctrl = '0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        // Reset values while held in reset.
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset owner", owner, 1);
        checkOutput("reset alu_ctrl", alu_ctrl, 3'b010);
        checkOutput("reset alu_srca", alu_srca, 0);
        checkOutput("reset alu_srcb", alu_srcb, 0);
        checkOutput("reset rsp_result", rsp_result, 0);
        checkOutput("reset rsp_zero", rsp_zero, 0);
        checkOutput("reset readies", {30'd0, req1_ready, req0_ready}, 0);
        checkOutput("reset rsp valids", {30'd0, rsp1_valid, rsp0_valid}, 0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
        checkOutput("reset rsp_err", rsp_err, 0);
`endif
        reset_n = 1'b1;

        // Table-driven single-request transactions.
        for (int i = 0; i < 8; i++) begin
            runTransaction($sformatf("vec%0d", i), vecs[i].port, vecs[i].a, vecs[i].b,
                           vecs[i].ctrl, vecs[i].ctrl, vecs[i].res, vecs[i].zero, 1'b0);
        end

        // Both requesters valid every cycle: grants alternate 0,1,0,1,0.
        doReset();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 32'd7, 32'd7, 3'b110);
        applyStimulus(1'b1, 1'b1, 32'd2, 32'd9, 3'b111);
        for (int g = 0; g < 5; g++) begin
            automatic logic exp_port = logic'(g % 2);
            #1;
            checkOutput($sformatf("rr%0d req0_ready", g), req0_ready, !exp_port);
            checkOutput($sformatf("rr%0d req1_ready", g), req1_ready, exp_port);
            @(negedge clk);
            #1;
            checkOutput($sformatf("rr%0d owner", g), owner, exp_port);
            @(negedge clk);
            #1;
            checkOutput($sformatf("rr%0d rsp0_valid", g), rsp0_valid, !exp_port);
            checkOutput($sformatf("rr%0d rsp1_valid", g), rsp1_valid, exp_port);
            checkOutput($sformatf("rr%0d result", g), rsp_result, exp_port ? 32'd1 : 32'd0);
            checkOutput($sformatf("rr%0d zero", g), rsp_zero, !exp_port);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        // Response backpressure on port 1 with req0 pending.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 32'hFF00FF00, 32'h0FF00FF0, 3'b000);
        #1;
        checkOutput("bp req1_ready", req1_ready, 1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 3'b000);
        applyStimulus(1'b0, 1'b1, 32'd10, 32'd20, 3'b010);
        #1;
        checkOutput("bp req0_ready in EXEC", req0_ready, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("bp%0d rsp1_valid", k), rsp1_valid, 1);
            checkOutput($sformatf("bp%0d rsp_result", k), rsp_result, 32'h0F000F00);
            checkOutput($sformatf("bp%0d req0_ready", k), req0_ready, 0);
            checkOutput($sformatf("bp%0d rsp0_valid", k), rsp0_valid, 0);
        end
        @(negedge clk);
        rsp1_ready = 1'b1;
        #1;
        checkOutput("bp rsp1_valid at take", rsp1_valid, 1);
        checkOutput("bp req0_ready at take", req0_ready, 0);
        @(negedge clk);
        rsp1_ready = 1'b0;
        #1;
        checkOutput("bp rsp1_valid after take", rsp1_valid, 0);
        checkOutput("bp req0_ready in IDLE", req0_ready, 1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'd10, 32'd20, 3'b010);
        @(negedge clk);
        #1;
        checkOutput("bp rsp0_valid", rsp0_valid, 1);
        checkOutput("bp req0 result", rsp_result, 32'd30);
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;

        // Operands change during EXEC; latched values must be used.
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 32'hF0, 32'h0F, 3'b001);
        #1;
        checkOutput("stab req0_ready", req0_ready, 1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h1234, 32'h5678, 3'b000);
        #1;
        checkOutput("stab alu_srca EXEC", alu_srca, 32'hF0);
        checkOutput("stab alu_srcb EXEC", alu_srcb, 32'h0F);
        checkOutput("stab alu_ctrl EXEC", alu_ctrl, 3'b001);
        @(negedge clk);
        #1;
        checkOutput("stab alu_srca RESP", alu_srca, 32'hF0);
        checkOutput("stab rsp0_valid", rsp0_valid, 1);
        checkOutput("stab result", rsp_result, 32'hFF);
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;

        // Reset mid-EXEC with owner=0; after release the tie goes to 0.
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 32'd100, 32'd1, 3'b110);
        #1;
        checkOutput("rst req0_ready accept", req0_ready, 1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 32'd40, 32'd2, 3'b010);
        reset_n = 1'b0;
        #1;
        checkOutput("rst busy", busy, 0);
        checkOutput("rst readies", {30'd0, req1_ready, req0_ready}, 0);
        checkOutput("rst rsp valids", {30'd0, rsp1_valid, rsp0_valid}, 0);
        checkOutput("rst owner", owner, 1);
        checkOutput("rst alu_srca", alu_srca, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("rst tie req0_ready", req0_ready, 1);
        checkOutput("rst tie req1_ready", req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        checkOutput("rst new alu_srca", alu_srca, 32'd100);
        @(negedge clk);
        #1;
        checkOutput("rst rsp0_valid", rsp0_valid, 1);
        checkOutput("rst result", rsp_result, 32'd99);
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;

`ifdef ALU_ARB_ILLEGAL_OP_EN
        runTransaction("illegal", 1'b0, 32'd4, 32'd4, 3'b011, 3'b010, 32'd0, 1'b1, 1'b1);
        runTransaction("legal after illegal", 1'b1, 32'hC, 32'hA, 3'b000, 3'b000,
                       32'h8, 1'b0, 1'b0);
`else
        runTransaction("unknown ctrl forwarded", 1'b0, 32'd4, 32'd4, 3'b011, 3'b011,
                       32'd8, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single-cycle ALU (add, sub, and, or, slt) between two requesters, e.g. the main datapath (port 0) and a branch/address unit (port 1).
- Round-robin arbitration with valid/ready request and response handshakes.
- Operands are latched and the ALU result is registered, so the ALU sees stable inputs for a full cycle.
- One operation is in flight at a time. The block sits between the requesters and the alu instance.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  op 0 accepted this cycle
- req0_srca, req0_srcb  in  DATA_W  operands
- req0_ctrl  in  3  ALU control code
- req1_valid, req1_ready, req1_srca, req1_srcb, req1_ctrl: same as port 0, for requester 1
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 takes result
- rsp1_valid, rsp1_ready: same as port 0, for requester 1
- rsp_result  out  DATA_W  registered ALU result, shared by both response ports
- rsp_zero  out  1  registered zero flag
- alu_srca, alu_srcb  out  DATA_W  to ALU
- alu_ctrl  out  3  to ALU
- alu_out  in  DATA_W  from ALU
- alu_zero  in  1  from ALU
- busy  out  1  state != IDLE
- owner  out  1  index of the current/last granted requester

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous, active-low.
- Reset values: state=IDLE; all ready/valid outputs 0; rsp_result=0; rsp_zero=0; alu_srca/srcb=0; alu_ctrl=3'b010; owner=1, so requester 0 wins the first tie.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqN_valid, pick the winner. A single requester wins outright; if both are valid, the winner is !owner.
  - Assert the winner's reqN_ready combinationally in the same cycle. The loser's ready stays 0.
  - On the clock edge, latch the winner's srca/srcb/ctrl into the alu_* registers, set owner=winner, and go to EXEC.
  - With no valid requests, stay in IDLE.
- EXEC:
  - ALU inputs have been stable since the edge.
  - At the end of the cycle, capture alu_out into rsp_result and alu_zero into rsp_zero, then go to RESP.
- RESP:
  - rspN_valid=1 for N=owner only.
  - Hold rsp_result/rsp_zero until rspN_ready=1. On that edge, rsp_valid drops and the FSM goes to IDLE.
  - No request is accepted in RESP.
- Latency: accept in cycle 0 -> rsp valid in cycle 2. Minimum initiation interval is 3 cycles per operation.
- Handshake stability:
  - A requester must hold valid and operands stable until ready.
  - The block holds rsp valid and data stable until ready.
  - Requests withdrawn before ready are not executed.
- Starvation: with both requesters continuously valid, grants alternate 0,1,0,1…
- Reset asserted mid-operation: the FSM returns to IDLE immediately, the in-flight op is discarded, and rsp_valid drops asynchronously.
- alu_* outputs change only on IDLE->EXEC edges. They are never driven from requester inputs combinationally.
- Arithmetic is entirely inside the ALU; the block adds no width conversion.

Optional Feature:
- Macro: ALU_ARB_ILLEGAL_OP_EN.
- When defined:
  - Adds output rsp_err (1 bit, reset 0).
  - Legal ctrl codes are 010, 110, 000, 001, 111. An accepted op with any other code still takes the IDLE->EXEC->RESP path.
  - For an illegal code, alu_ctrl is driven 3'b010 and rsp_result is forced to 0, rsp_zero=1, rsp_err=1.
  - rsp_err is 0 for legal ops.
- When undefined: no rsp_err port, and ctrl is forwarded unchanged, so the ALU's default add applies.

Test Plan:
- Reset then single request: req0 srca=5, srcb=3, ctrl=010 -> req0_ready in cycle 0; rsp0_valid in cycle 2 with result=8, zero=0; rsp1_valid stays 0.
- Both valid every cycle, back to back:
  - Port 0: sub with srca=7, srcb=7 -> first grant, result=0, zero=1.
  - Port 1: slt with srca=2, srcb=9 -> second grant, result=1.
  - Then grants continue alternating 0,1,0.
- Response backpressure: hold rsp1_ready=0 for 4 cycles with a new req0 pending -> rsp1_valid and result held unchanged, req0_ready=0 throughout, req0 granted in the IDLE cycle after rsp1_ready=1.
- Reset mid-EXEC: deassert reset_n one cycle after accept -> all valid/ready=0 immediately; after release, the next tie grants requester 0.
- Operand stability: change req0 operands while in EXEC -> alu_srca/srcb unchanged, result matches the latched values (and ctrl=001 on 0xF0|0x0F gives 0xFF).
- ALU_ARB_ILLEGAL_OP_EN: ctrl=011 -> rsp_err=1, result=0, zero=1, alu_ctrl=010. Then a legal ctrl=000 op -> rsp_err=0.
